// File: rtl/xgmii_scrambler.sv
// xgmii_scrambler: self-synchronous 1+x^39+x^58 scrambler with a 2-entry skid buffer on a 32-bit datapath.
// Optional macro SCRAMBLER_BYPASS_EN adds i_bypass to pass words through unscrambled with the LFSR frozen.
module xgmii_scrambler #(
    parameter int          DATA_WIDTH = 32,
    parameter int          HDR_WIDTH  = 2,
    parameter logic [57:0] SEED       = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_encoded_data,
    input  logic [HDR_WIDTH-1:0]  i_sync_hdr,
    input  logic                  i_encoded_data_valid,
`ifdef SCRAMBLER_BYPASS_EN
    input  logic                  i_bypass,
`endif
    output logic                  o_scrambler_trdy,
    output logic [DATA_WIDTH-1:0] o_scrambled_data,
    output logic [HDR_WIDTH-1:0]  o_sync_hdr,
    output logic                  o_hdr_first,
    output logic                  o_scrambled_valid,
    input  logic                  i_gearbox_rdy,
    output logic                  o_hdr_err
);
    localparam int EW = DATA_WIDTH + HDR_WIDTH + 1;

    logic [57:0]           lfsr_q, lfsr_d, s;
    logic [DATA_WIDTH-1:0] scr;
    logic [EW-1:0]         head_q, head_d, tail_q, tail_d, entry;
    logic [1:0]            cnt_q, cnt_d;
    logic [HDR_WIDTH-1:0]  hdr_q, hdr_d, hdr_cur;
    logic                  trdy_q, phase_q, phase_d;
    logic                  push, pop, bypass;

`ifdef SCRAMBLER_BYPASS_EN
    assign bypass = i_bypass;
`else
    assign bypass = 1'b0;
`endif

    assign push    = i_encoded_data_valid & trdy_q;
    assign pop     = (cnt_q != 2'd0) & i_gearbox_rdy;
    assign hdr_cur = phase_q ? hdr_q : i_sync_hdr;

    // Bit 0 is scrambled first; s[0] always holds the most recent scrambled bit.
    always_comb begin
        s   = lfsr_q;
        scr = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            scr[i] = i_encoded_data[i] ^ s[38] ^ s[57];
            s      = {s[56:0], scr[i]};
        end
    end

    assign entry   = {~phase_q, hdr_cur, bypass ? i_encoded_data : scr};
    assign lfsr_d  = (push & ~bypass) ? s : lfsr_q;
    assign phase_d = phase_q ^ push;
    assign hdr_d   = (push & ~phase_q) ? i_sync_hdr : hdr_q;
    assign cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};

    // head is the output register; tail only fills while head is stalled.
    assign head_d = (pop & (cnt_q == 2'd2)) ? tail_q :
                    (push & (pop | (cnt_q == 2'd0))) ? entry : head_q;
    assign tail_d = (push & ((cnt_q == 2'd2) | ((cnt_q == 2'd1) & ~pop))) ? entry : tail_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lfsr_q  <= SEED;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= 2'd0;
            hdr_q   <= '0;
            phase_q <= 1'b0;
            trdy_q  <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            phase_q <= phase_d;
            trdy_q  <= cnt_d < 2'd2;
        end
    end

    assign o_scrambler_trdy  = trdy_q;
    assign o_scrambled_valid = cnt_q != 2'd0;
    assign o_hdr_first       = head_q[EW-1];
    assign o_sync_hdr        = head_q[DATA_WIDTH +: HDR_WIDTH];
    assign o_scrambled_data  = head_q[DATA_WIDTH-1:0];
    assign o_hdr_err         = push & ~phase_q & ((i_sync_hdr == '0) | (i_sync_hdr == '1));
endmodule

// File: tb/tb_xgmii_scrambler.sv
// tb_xgmii_scrambler: random and directed stimulus against a bit-recurrence scrambler/descrambler model.
module tb_xgmii_scrambler;
    localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [31:0] i_encoded_data = '0;
    logic [1:0]  i_sync_hdr = '0;
    logic        i_encoded_data_valid = 1'b0;
    logic        i_gearbox_rdy = 1'b0;
`ifdef SCRAMBLER_BYPASS_EN
    logic        i_bypass = 1'b0;
`endif
    logic        o_scrambler_trdy, o_hdr_first, o_scrambled_valid, o_hdr_err;
    logic [31:0] o_scrambled_data;
    logic [1:0]  o_sync_hdr;

    xgmii_scrambler dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_encoded_data(i_encoded_data), .i_sync_hdr(i_sync_hdr),
        .i_encoded_data_valid(i_encoded_data_valid),
`ifdef SCRAMBLER_BYPASS_EN
        .i_bypass(i_bypass),
`endif
        .o_scrambler_trdy(o_scrambler_trdy), .o_scrambled_data(o_scrambled_data),
        .o_sync_hdr(o_sync_hdr), .o_hdr_first(o_hdr_first),
        .o_scrambled_valid(o_scrambled_valid), .i_gearbox_rdy(i_gearbox_rdy),
        .o_hdr_err(o_hdr_err)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0, n_fail = 0, err_cnt = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {logic [31:0] d; logic [31:0] orig; logic [1:0] h; bit f; bit byp;} ent_t;
    ent_t        exq[$];
    bit          ybits[$];
    bit          rbits[$];
    bit          mphase, exp_trdy;
    logic [1:0]  mhdr;
    logic [31:0] got_d[$];
    logic [1:0]  got_h[$];
    bit          got_f[$];

    // Scrambled bit stream y[n] = x[n] ^ y[n-39] ^ y[n-58], with the seed as the 58 bits before the first.
    function automatic void model_reset();
        ybits = {};
        rbits = {};
        for (int k = 57; k >= 0; k--) begin
            ybits.push_back(SEED[k]);
            rbits.push_back(SEED[k]);
        end
        exq = {};
        mphase = 1'b0;
        mhdr = '0;
        exp_trdy = 1'b0;
    endfunction

    function automatic logic [31:0] scramble(logic [31:0] x);
        logic [31:0] y;
        int n;
        for (int i = 0; i < 32; i++) begin
            n = ybits.size();
            y[i] = x[i] ^ ybits[n-39] ^ ybits[n-58];
            ybits.push_back(y[i]);
        end
        return y;
    endfunction

    function automatic logic [31:0] descramble(logic [31:0] y);
        logic [31:0] x;
        int n;
        for (int i = 0; i < 32; i++) begin
            n = rbits.size();
            x[i] = y[i] ^ rbits[n-39] ^ rbits[n-58];
            rbits.push_back(y[i]);
        end
        return x;
    endfunction

    always @(negedge i_clk) begin
        ent_t e;
        bit in_x, bad;
        if (!i_reset_n) begin
            check("reset_outputs", {o_scrambled_valid, o_scrambled_data, o_sync_hdr, o_hdr_first,
                                    o_hdr_err, o_scrambler_trdy}, '0);
            model_reset();
        end else begin
            check("trdy", o_scrambler_trdy, exp_trdy);
            check("valid", o_scrambled_valid, exq.size() != 0);
            if (exq.size() != 0) begin
                check("data", o_scrambled_data, exq[0].d);
                check("hdr", o_sync_hdr, exq[0].h);
                check("first", o_hdr_first, exq[0].f);
                if (i_gearbox_rdy) begin
                    if (!exq[0].byp) check("descrambled", descramble(o_scrambled_data), exq[0].orig);
                    got_d.push_back(o_scrambled_data);
                    got_h.push_back(o_sync_hdr);
                    got_f.push_back(o_hdr_first);
                    void'(exq.pop_front());
                end
            end
            in_x = i_encoded_data_valid & o_scrambler_trdy;
            bad  = in_x & !mphase & (i_sync_hdr == 2'b00 || i_sync_hdr == 2'b11);
            check("hdr_err", o_hdr_err, bad);
            if (o_hdr_err) err_cnt++;
            if (in_x) begin
                if (!mphase) mhdr = i_sync_hdr;
                e.h = mhdr;
                e.f = !mphase;
                e.orig = i_encoded_data;
`ifdef SCRAMBLER_BYPASS_EN
                e.byp = i_bypass;
`else
                e.byp = 1'b0;
`endif
                e.d = e.byp ? i_encoded_data : scramble(i_encoded_data);
                exq.push_back(e);
                mphase = !mphase;
            end
            exp_trdy = exq.size() < 2;
        end
    end

    task automatic clear_log();
        got_d = {};
        got_h = {};
        got_f = {};
        err_cnt = 0;
    endtask

    task automatic send_word(logic [31:0] d, logic [1:0] h);
        int k = 0;
        @(posedge i_clk);
        #1;
        i_encoded_data = d;
        i_sync_hdr = h;
        i_encoded_data_valid = 1'b1;
        @(negedge i_clk);
        while (!o_scrambler_trdy && k < 50) begin
            @(negedge i_clk);
            k++;
        end
        check("send_accepted", k < 50, 1);
    endtask

    task automatic idle();
        @(posedge i_clk);
        #1;
        i_encoded_data_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        i_gearbox_rdy = 1'b1;
        while (exq.size() != 0 && k < 100) begin
            @(negedge i_clk);
            k++;
        end
        check("drain_empty", exq.size(), 0);
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #3;
        i_reset_n = 1'b0;
        i_encoded_data_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
    endtask

    task automatic rand_stream(int n);
        int acc_n = 0, cyc = 0;
        bit acc = 1'b1;
        while (acc_n < n && cyc < 20 * n) begin
            @(posedge i_clk);
            #1;
            if (acc || !i_encoded_data_valid) begin
                i_encoded_data_valid = $urandom_range(0, 9) != 0;
                i_encoded_data = $urandom;
                i_sync_hdr = 2'($urandom_range(0, 3));
            end
            i_gearbox_rdy = $urandom_range(0, 3) != 0;
            @(negedge i_clk);
            acc = i_encoded_data_valid & o_scrambler_trdy;
            acc_n += int'(acc);
            cyc++;
        end
        check("stream_count", acc_n, n);
        idle();
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int acc_n;
        bit acc;
        model_reset();
        i_gearbox_rdy = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;

        clear_log();
        send_word(32'h0, 2'b10);
        send_word(32'h0, 2'b10);
        idle();
        drain();
        check("vec_w0", got_d[0], 32'h0000_0000);
        check("vec_w1", got_d[1], 32'h03FF_FF80);
        check("vec_first", {got_f[0], got_f[1]}, 2'b10);
        check("vec_hdr", {got_h[0], got_h[1]}, 4'b1010);

        clear_log();
        send_word($urandom, 2'b11);
        send_word($urandom, 2'b00);
        send_word($urandom, 2'b01);
        send_word($urandom, 2'b11);
        send_word($urandom, 2'b10);
        send_word($urandom, 2'b00);
        idle();
        drain();
        check("err_pulses", err_cnt, 1);
        check("err_hdr_fwd", {got_h[0], got_h[1]}, 4'b1111);
        check("hdr_01_fwd", {got_h[2], got_h[3]}, 4'b0101);
        check("hdr_10_fwd", {got_h[4], got_h[5]}, 4'b1010);

        acc_n = 0;
        acc = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge i_clk);
            #1;
            i_gearbox_rdy = 1'b0;
            if (acc) begin
                i_encoded_data = $urandom;
                i_sync_hdr = 2'b10;
            end
            i_encoded_data_valid = 1'b1;
            @(negedge i_clk);
            acc = i_encoded_data_valid & o_scrambler_trdy;
            acc_n += int'(acc);
        end
        check("stall_accepts", acc_n, 2);
        @(posedge i_clk);
        #1;
        i_gearbox_rdy = 1'b1;
        begin
            int k = 0;
            @(negedge i_clk);
            while (!o_scrambler_trdy && k < 20) begin
                @(negedge i_clk);
                k++;
            end
            check("stall_release", k < 20, 1);
        end
        send_word($urandom, 2'b01);
        idle();
        drain();

        rand_stream(1000);

        send_word($urandom, 2'b01);
        send_word($urandom, 2'b01);
        send_word($urandom, 2'b10);
        @(posedge i_clk);
        #2;
        check("pre_reset_valid", o_scrambled_valid, 1);
        #1;
        i_reset_n = 1'b0;
        i_encoded_data_valid = 1'b0;
        #1;
        check("async_reset", {o_scrambled_valid, o_scrambled_data, o_sync_hdr, o_hdr_first,
                              o_scrambler_trdy}, '0);
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        clear_log();
        send_word(32'h0, 2'b01);
        send_word(32'h0, 2'b01);
        idle();
        drain();
        check("rst_w0", got_d[0], 32'h0000_0000);
        check("rst_w1", got_d[1], 32'h03FF_FF80);
        check("rst_first", got_f[0], 1);

`ifdef SCRAMBLER_BYPASS_EN
        do_reset();
        clear_log();
        i_bypass = 1'b1;
        send_word(32'hDEAD_BEEF, 2'b10);
        @(posedge i_clk);
        #1;
        i_bypass = 1'b0;
        i_encoded_data = 32'h0;
        @(negedge i_clk);
        send_word(32'h0, 2'b10);
        idle();
        drain();
        check("byp_word", got_d[0], 32'hDEAD_BEEF);
        check("byp_next0", got_d[1], 32'h0000_0000);
        check("byp_next1", got_d[2], 32'h03FF_FF80);
`else
        do_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
